addr_select_decoder: RTL and testbench
======================================

// Module: addr_select_decoder
// PURPOSE
//  Parametrised, registered successor to the combinational address decoder.
//  Decodes a host register address into a one-hot slave select and holds that select for a whole access.
//  Waits for the selected slave's acknowledge and returns an ok/error response to the host.
//  Sits between the HDMI control-bus master and the peripheral register blocks.
//  Adds unmapped-address errors and a timeout.
// PARAMETERS
//  ADDR_W      8   host address width
//  REGION_W    4   low address bits per slave region; each slave owns 2^REGION_W addresses
//  NUM_SLAVES  8   number of select lines; must be <= 2^(ADDR_W-REGION_W)
//  TIMEOUT     16  cycles to wait for slave ack before error; >= 2
// PORTS
//  clk       in   1           single clock, rising edge
//  rstN      in   1           asynchronous active-low reset
//  en        in   1           decoder enable; gates acceptance of new requests only
//  reqValid  in   1           host request valid
//  reqReady  out  1           host request ready
//  reqAddr   in   ADDR_W      host address
//  selOut    out  NUM_SLAVES  registered one-hot slave select
//  localAddr out  REGION_W    registered reqAddr[REGION_W-1:0]
//  slvAck    in   NUM_SLAVES  per-slave access acknowledge
//  rspValid  out  1           response valid
//  rspReady  in   1           host response ready
//  rspErr    out  1           1 = unmapped address or timeout
// BEHAVIOUR
//  Reset (rstN low, async): state=IDLE; selOut=0; localAddr=0; rspValid=0; rspErr=0; timer=0.
//   reqReady=0 while rstN is low.
//  idx = reqAddr[ADDR_W-1:REGION_W]; the address is mapped iff idx < NUM_SLAVES.
//  FSM, one access at a time, three states:
//   IDLE:
//    - reqReady = en (combinational, IDLE only).
//    - Accept on reqValid & reqReady: latch idx and localAddr.
//    - Mapped: go to ACCESS; selOut = 1<<idx from the next cycle; timer=0.
//    - Unmapped: go to RESP with rspErr=1; selOut stays 0.
//   ACCESS:
//    - selOut is held and timer increments each cycle.
//    - slvAck[idx] sampled high: go to RESP with rspErr=0; selOut=0.
//    - Else if timer==TIMEOUT-1: go to RESP with rspErr=1; selOut=0.
//    - If ack and timeout occur in the same cycle, ack wins (rspErr=0).
//    - Acks on non-selected lines are ignored.
//   RESP:
//    - rspValid=1; rspErr is held stable.
//    - On rspReady: go to IDLE; rspValid=0 next cycle.
//  Latency (accept at cycle 0):
//   - selOut valid at cycle 1.
//   - Ack at cycle 1 gives rspValid at cycle 2.
//   - Unmapped address gives rspValid at cycle 1.
//   - No ack gives rspValid at cycle 1+TIMEOUT.
//  en falling mid-access does not abort the access; it only blocks the next acceptance.
//  selOut is always zero or one-hot, never multi-hot, and is never asserted outside ACCESS.
//  The next request can be accepted no earlier than the cycle after rspValid falls.
//  reqAddr and slvAck are don't-care outside their sampling cycles.
// STRUCTURE
//  addr_dec_pkg:
//   - State encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
//   - Width helper: timer width = clog2(TIMEOUT).
//  Sub-module timeout_counter:
//   - Inputs clr, inc; output hit at count TIMEOUT-1.
//   - Same clk/rstN as the parent.
//  The top level holds the FSM, the index/localAddr registers and the one-hot select register.
// TESTING (default params)
//  1 Reset: rstN low mid-ACCESS -> selOut=0, rspValid=0 immediately; reqReady=en after release.
//  2 Mapped: reqAddr=8'h35 accepted, slvAck[3]=1 at cycle 2 -> selOut=8'h08 on cycles 1-2,
//    localAddr=4'h5, rspValid=1 with rspErr=0 at cycle 3.
//  3 Unmapped: NUM_SLAVES=4, reqAddr=8'h52 -> selOut stays 0; rspValid=1, rspErr=1 at cycle 1.
//  4 Timeout: reqAddr=8'h10, no ack -> selOut=8'h02 for 16 cycles; rspErr=1 at cycle 17.
//    Also: ack coincident with the last timer cycle -> rspErr=0.
//  5 Backpressure/en: hold rspReady=0 for 5 cycles -> rspValid and rspErr stable, reqReady=0.
//    Drop en during ACCESS -> access completes, then reqReady stays 0 until en returns.
//  6 Stray ack: slvAck=8'hF7 while idx=3 is selected -> no response until slvAck[3] rises.

Source files
------------

// File: rtl/addr_dec_pkg.sv
// addr_dec_pkg
//   Shared definitions for the registered address-select decoder:
//   FSM state encoding and the timeout counter width helper.
package addr_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Counter wide enough to reach TIMEOUT-1; never narrower than one bit.
  function automatic int timer_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/addr_select_decoder_timeout_counter.sv
// timeout_counter
//   Up-counter that measures how long the decoder has been waiting for a
//   slave acknowledge.
// Ports:
//   clk   in  clock, rising edge
//   rstN  in  asynchronous active-low reset
//   clr   in  synchronous clear to zero (has priority over inc)
//   inc   in  advance the count by one
//   hit   out count has reached TIMEOUT-1
module timeout_counter
  import addr_dec_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstN,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CNT_W = timer_w(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = (cnt == LAST);

endmodule

// File: rtl/addr_select_decoder.sv
// addr_select_decoder
//   Registered address decoder between the control-bus master and the
//   peripheral register blocks. Turns a host address into a one-hot slave
//   select held for the whole access, waits for that slave's acknowledge and
//   returns an ok/error response (unmapped address or timeout).
// Ports:
//   clk        in   clock, rising edge
//   rstN       in   asynchronous active-low reset
//   en         in   gates acceptance of new requests only
//   reqValid   in   host request valid
//   reqReady   out  host request ready (IDLE and en)
//   reqAddr    in   host address [ADDR_W]
//   selOut     out  registered one-hot slave select [NUM_SLAVES]
//   localAddr  out  registered low address bits [REGION_W]
//   slvAck     in   per-slave acknowledge [NUM_SLAVES]
//   rspValid   out  response valid
//   rspReady   in   host response ready
//   rspErr     out  1 = unmapped address or timeout
//
// state  | meaning
// IDLE   | waiting for a request; reqReady follows en
// ACCESS | select held, waiting for ack of the selected slave or timeout
// RESP   | response presented until the host takes it
module addr_select_decoder
  import addr_dec_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int REGION_W   = 4,
  parameter int NUM_SLAVES = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  en,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [ADDR_W-1:0]     reqAddr,
  output logic [NUM_SLAVES-1:0] selOut,
  output logic [REGION_W-1:0]   localAddr,
  input  logic [NUM_SLAVES-1:0] slvAck,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic                  rspErr
);

  localparam int IDX_W = ADDR_W - REGION_W;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      req_idx;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [REGION_W-1:0]   local_q;
  logic                  rsp_err_q;
  logic                  mapped;
  logic                  accept;
  logic                  ack_hit;
  logic                  tmr_clr;
  logic                  tmr_inc;
  logic                  tmr_hit;
  logic                  access_done;

  assign req_idx = reqAddr[ADDR_W-1:REGION_W];

  // Indices at or above NUM_SLAVES decode to all-zero, which doubles as
  // the unmapped flag.
  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (req_idx == IDX_W'(i)) dec_sel[i] = 1'b1;
    end
  end

  assign mapped = |dec_sel;
  assign accept = reqValid & reqReady;

  // sel_q is one-hot in ACCESS, so masking filters out stray acks.
  assign ack_hit     = |(slvAck & sel_q);
  assign access_done = ack_hit | tmr_hit;

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_counter (
    .clk  (clk),
    .rstN (rstN),
    .clr  (tmr_clr),
    .inc  (tmr_inc),
    .hit  (tmr_hit)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = mapped ? ACCESS : RESP;
      ACCESS:  if (access_done) state_d = RESP;
      RESP:    if (rspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // reqReady is gated by rstN so the host sees not-ready while held in reset.
  always_comb begin
    reqReady = 1'b0;
    rspValid = 1'b0;
    tmr_clr  = 1'b1;
    tmr_inc  = 1'b0;
    case (state_q)
      IDLE:   reqReady = en & rstN;
      ACCESS: begin
        tmr_clr = 1'b0;
        tmr_inc = 1'b1;
      end
      RESP:   rspValid = 1'b1;
      default: ;
    endcase
  end

  // Ack takes priority over timeout when both land in the same cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sel_q     <= '0;
      local_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && accept) begin
        sel_q   <= dec_sel;
        local_q <= reqAddr[REGION_W-1:0];
        if (!mapped) rsp_err_q <= 1'b1;
      end else if (state_q == ACCESS && access_done) begin
        sel_q     <= '0;
        rsp_err_q <= ~ack_hit;
      end
    end
  end

  assign selOut    = sel_q;
  assign localAddr = local_q;
  assign rspErr    = rsp_err_q;

endmodule

// File: tb/tb_addr_select_decoder.sv
module tb_addr_select_decoder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       en = 1'b1;
  logic       reqValid = 1'b0;
  logic [7:0] reqAddr = '0;
  logic [7:0] slvAck = '0;
  logic       rspReady = 1'b0;
  logic       reqReady;
  logic [7:0] selOut;
  logic [3:0] localAddr;
  logic       rspValid;
  logic       rspErr;

  logic       en4 = 1'b1;
  logic       reqValid4 = 1'b0;
  logic [7:0] reqAddr4 = '0;
  logic [3:0] slvAck4 = '0;
  logic       rspReady4 = 1'b0;
  logic       reqReady4;
  logic [3:0] selOut4;
  logic [3:0] localAddr4;
  logic       rspValid4;
  logic       rspErr4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addr_select_decoder dut (
    .clk(clk), .rstN(rstN), .en(en), .reqValid(reqValid), .reqReady(reqReady),
    .reqAddr(reqAddr), .selOut(selOut), .localAddr(localAddr), .slvAck(slvAck),
    .rspValid(rspValid), .rspReady(rspReady), .rspErr(rspErr)
  );

  addr_select_decoder #(.NUM_SLAVES(4)) dut4 (
    .clk(clk), .rstN(rstN), .en(en4), .reqValid(reqValid4), .reqReady(reqReady4),
    .reqAddr(reqAddr4), .selOut(selOut4), .localAddr(localAddr4), .slvAck(slvAck4),
    .rspValid(rspValid4), .rspReady(rspReady4), .rspErr(rspErr4)
  );

  typedef struct {
    logic [7:0] addr;
    int         ack_cyc;   // cycle after accept in which the target ack is driven; 0 = never
    logic [7:0] stray;     // acks on other lines every cycle
    int         bp;        // cycles of rspReady=0 backpressure
    int         en_off;    // cycle in which en is dropped; 0 = never
    logic [7:0] exp_sel;
    logic [3:0] exp_loc;
    int         exp_lat;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: decode from the address arithmetic, latency from the ack rule.
  function automatic void model(input logic [7:0] addr, input int ack_cyc,
                                output logic [7:0] sel, output int lat, output logic err);
    int idx;
    idx = int'(addr) / 16;
    if (idx >= 8) begin
      sel = 8'h00; lat = 1; err = 1'b1;
    end else begin
      sel = 8'(1 << idx);
      if (ack_cyc >= 1 && ack_cyc <= TO) begin
        lat = ack_cyc + 1; err = 1'b0;
      end else begin
        lat = TO + 1; err = 1'b1;
      end
    end
  endfunction

  task automatic run_txn(input string tag, input logic [7:0] addr, input int ack_cyc,
                         input logic [7:0] stray, input int bp, input int en_off,
                         input logic [7:0] exp_sel, input logic [3:0] exp_loc,
                         input int exp_lat, input logic exp_err);
    logic [7:0] target, sel_or;
    logic [3:0] loc;
    int lat, sel_cyc, bad;
    target = (addr[7:4] < 4'd8) ? 8'(1 << addr[7:4]) : 8'h00;
    chk({tag, "_ready"}, reqReady, 1);
    reqValid = 1'b1;
    reqAddr  = addr;
    slvAck   = stray & ~target;
    step();
    reqValid = 1'b0;
    reqAddr  = 8'($urandom);
    lat = -1; sel_or = '0; sel_cyc = 0; bad = 0;
    loc = localAddr;
    for (int c = 1; c <= 40; c++) begin
      if (c == en_off) en = 1'b0;
      if (rspValid) begin
        lat = c;
        break;
      end
      sel_or |= selOut;
      if (selOut != 8'h00) sel_cyc++;
      if (!$onehot0(selOut)) bad++;
      slvAck = (stray & ~target) | ((c == ack_cyc) ? target : 8'h00);
      step();
    end
    slvAck = 8'($urandom);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_err"}, rspErr, exp_err);
    chk({tag, "_sel"}, sel_or, exp_sel);
    chk({tag, "_selcyc"}, sel_cyc, (exp_sel != 8'h00) ? exp_lat - 1 : 0);
    chk({tag, "_onehot"}, bad, 0);
    chk({tag, "_loc"}, loc, exp_loc);
    if (lat > 0) begin
      for (int b = 0; b < bp; b++) begin
        step();
        chk({tag, "_bp_valid"}, rspValid, 1);
        chk({tag, "_bp_err"}, rspErr, exp_err);
        chk({tag, "_bp_ready"}, reqReady, 0);
      end
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    slvAck   = 8'h00;
    chk({tag, "_rsp_drop"}, rspValid, 0);
    chk({tag, "_idle_ready"}, reqReady, en);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, st, esel;
    int ac, bp, elat;
    logic eerr;

    vecs[0] = '{8'h35, 2,  8'h00, 0, 0, 8'h08, 4'h5, 3,  1'b0};
    vecs[1] = '{8'h10, 0,  8'h00, 5, 0, 8'h02, 4'h0, 17, 1'b1};
    vecs[2] = '{8'h7F, 16, 8'h00, 0, 0, 8'h80, 4'hF, 17, 1'b0};
    vecs[3] = '{8'h35, 5,  8'hF7, 2, 0, 8'h08, 4'h5, 6,  1'b0};
    vecs[4] = '{8'h90, 0,  8'hFF, 5, 0, 8'h00, 4'h0, 1,  1'b1};
    vecs[5] = '{8'h00, 1,  8'h00, 0, 0, 8'h01, 4'h0, 2,  1'b0};
    vecs[6] = '{8'h6A, 15, 8'h3F, 1, 0, 8'h40, 4'hA, 16, 1'b0};
    vecs[7] = '{8'h20, 3,  8'h00, 0, 1, 8'h04, 4'h0, 4,  1'b0};

    // Reset state while rstN is held low
    #12;
    chk("rst_sel", selOut, 0);
    chk("rst_valid", rspValid, 0);
    chk("rst_err", rspErr, 0);
    chk("rst_loc", localAddr, 0);
    chk("rst_ready", reqReady, 0);
    @(negedge clk);
    rstN = 1'b1;
    step();
    chk("post_rst_ready", reqReady, 1);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ack_cyc, vecs[i].stray,
              vecs[i].bp, vecs[i].en_off, vecs[i].exp_sel, vecs[i].exp_loc,
              vecs[i].exp_lat, vecs[i].exp_err);
    end

    // en stays low after the last vector: requests must not be accepted
    reqValid = 1'b1;
    reqAddr  = 8'h35;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_low_ready", reqReady, 0);
      chk("en_low_sel", selOut, 0);
      chk("en_low_valid", rspValid, 0);
    end
    reqValid = 1'b0;
    en = 1'b1;
    #1;
    chk("en_back_ready", reqReady, 1);
    step();

    // Reset asserted in the middle of an access
    reqValid = 1'b1;
    reqAddr  = 8'h35;
    step();
    reqValid = 1'b0;
    step();
    step();
    chk("midrst_pre_sel", selOut, 8'h08);
    rstN = 1'b0;
    #1;
    chk("midrst_sel", selOut, 0);
    chk("midrst_valid", rspValid, 0);
    chk("midrst_ready", reqReady, 0);
    @(negedge clk);
    rstN = 1'b1;
    step();
    chk("midrst_rel_ready", reqReady, 1);
    chk("midrst_rel_sel", selOut, 0);
    en = 1'b0;
    #1;
    chk("midrst_en_ready", reqReady, 0);
    en = 1'b1;
    step();

    // Four-slave instance: 0x52 is unmapped
    chk("ns4_ready", reqReady4, 1);
    reqValid4 = 1'b1;
    reqAddr4  = 8'h52;
    step();
    reqValid4 = 1'b0;
    chk("ns4_valid", rspValid4, 1);
    chk("ns4_err", rspErr4, 1);
    chk("ns4_sel", selOut4, 0);
    chk("ns4_loc", localAddr4, 4'h2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ns4_bp_sel", selOut4, 0);
      chk("ns4_bp_valid", rspValid4, 1);
    end
    rspReady4 = 1'b1;
    step();
    rspReady4 = 1'b0;
    chk("ns4_drop", rspValid4, 0);
    // Four-slave instance: 0x35 is mapped, ack in cycle 1
    reqValid4 = 1'b1;
    reqAddr4  = 8'h35;
    step();
    reqValid4 = 1'b0;
    chk("ns4_m_sel", selOut4, 4'h8);
    slvAck4 = 4'h8;
    step();
    slvAck4 = 4'h0;
    chk("ns4_m_valid", rspValid4, 1);
    chk("ns4_m_err", rspErr4, 0);
    chk("ns4_m_sel_off", selOut4, 0);
    rspReady4 = 1'b1;
    step();
    rspReady4 = 1'b0;

    // Randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      a  = 8'($urandom_range(0, 255));
      ac = $urandom_range(0, 20);
      st = 8'($urandom);
      bp = $urandom_range(0, 3);
      model(a, ac, esel, elat, eerr);
      run_txn($sformatf("rnd%0d", n), a, ac, st, bp, 0, esel, a[3:0], elat, eerr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
